// File: rtl/rx_packet_ctrl_if.sv
// Byte-stream and write-side signal bundle for the USB receive control stage.
// The slave modport is the controller's view; master is the driving environment.
interface rx_packet_ctrl_if #(
    parameter int CNT_W = 7
);
    logic             d_edge;
    logic             byte_valid;
    logic [7:0]       rx_byte;
    logic             eop;
    logic             fifo_full;
    logic             w_enable;
    logic [7:0]       w_data;
    logic [3:0]       pid;
    logic             pid_valid;
    logic             rcving;
    logic             r_error;
    logic [CNT_W-1:0] byte_count;

    modport slave (
        input  d_edge, byte_valid, rx_byte, eop, fifo_full,
        output w_enable, w_data, pid, pid_valid, rcving, r_error, byte_count
    );

    modport master (
        output d_edge, byte_valid, rx_byte, eop, fifo_full,
        input  w_enable, w_data, pid, pid_valid, rcving, r_error, byte_count
    );
endinterface

// File: rtl/rx_packet_ctrl.sv
// USB receive control: checks SYNC and PID complement, forwards PID and payload
// bytes to the downstream write port, and raises a sticky error on bad packets.
module rx_packet_ctrl #(
    parameter int MAX_BYTES = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    rx_packet_ctrl_if.slave   bus
);
    localparam int                 CNT_W   = $clog2(MAX_BYTES + 1);
    localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_BYTES);
    localparam logic [7:0]         SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        PID     = 3'd2,
        PAYLOAD = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             w_enable_q, w_enable_d;
    logic [7:0]       w_data_q, w_data_d;
    logic [3:0]       pid_q, pid_d;
    logic             pid_valid_q, pid_valid_d;
    logic             rcving_q, rcving_d;
    logic             r_error_q, r_error_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic sync_ok, pid_accept, pay_accept;

    assign sync_ok    = (bus.rx_byte == SYNC_BYTE);
    assign pid_accept = (bus.rx_byte[7:4] == ~bus.rx_byte[3:0]) && !bus.fifo_full;
    assign pay_accept = (count_q < MAX_CNT) && !bus.fifo_full;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            w_enable_q  <= 1'b0;
            w_data_q    <= 8'h00;
            pid_q       <= 4'h0;
            pid_valid_q <= 1'b0;
            rcving_q    <= 1'b0;
            r_error_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            w_enable_q  <= w_enable_d;
            w_data_q    <= w_data_d;
            pid_q       <= pid_d;
            pid_valid_q <= pid_valid_d;
            rcving_q    <= rcving_d;
            r_error_q   <= r_error_d;
            count_q     <= count_d;
        end
    end

    // A byte arriving together with eop is judged first; eop then wins the state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.d_edge) state_d = SYNC;
            SYNC:    if (bus.byte_valid) state_d = sync_ok ? PID : ERR;
            PID:     if (bus.byte_valid) state_d = pid_accept ? PAYLOAD : ERR;
            PAYLOAD: if (bus.byte_valid && !pay_accept) state_d = ERR;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && bus.eop) state_d = IDLE;
    end

    // NOTE: every output-next value gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_enable_d  = 1'b0;
        pid_valid_d = 1'b0;
        w_data_d    = w_data_q;
        pid_d       = pid_q;
        rcving_d    = rcving_q;
        r_error_d   = r_error_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (bus.d_edge) begin
                    rcving_d  = 1'b1;
                    r_error_d = 1'b0;
                    count_d   = '0;
                end
            end
            SYNC: begin
                if (bus.byte_valid) begin
                    if (!sync_ok) r_error_d = 1'b1;
                end else if (bus.eop) begin
                    r_error_d = 1'b1;
                end
            end
            PID: begin
                if (bus.byte_valid) begin
                    if (pid_accept) begin
                        w_enable_d  = 1'b1;
                        w_data_d    = bus.rx_byte;
                        pid_d       = bus.rx_byte[7:4];
                        pid_valid_d = 1'b1;
                    end else begin
                        r_error_d = 1'b1;
                    end
                end else if (bus.eop) begin
                    r_error_d = 1'b1;
                end
            end
            PAYLOAD: begin
                if (bus.byte_valid) begin
                    if (pay_accept) begin
                        w_enable_d = 1'b1;
                        w_data_d   = bus.rx_byte;
                        count_d    = count_q + CNT_W'(1);
                    end else begin
                        r_error_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (state_q != IDLE && bus.eop) rcving_d = 1'b0;
    end

    assign bus.w_enable   = w_enable_q;
    assign bus.w_data     = w_data_q;
    assign bus.pid        = pid_q;
    assign bus.pid_valid  = pid_valid_q;
    assign bus.rcving     = rcving_q;
    assign bus.r_error    = r_error_q;
    assign bus.byte_count = count_q;
endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Scoreboard bench for rx_packet_ctrl: expected writes are queued as bytes are
// driven and matched (data and exact cycle) against w_enable strobes.
module tb_rx_packet_ctrl;
    localparam int MAXB  = 4;
    localparam int CNT_W = 3;

    logic clk;
    logic n_rst;
    int   cyc;
    int   checks;
    int   errors;
    int   pv_cnt;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb_q[$];
    exp_t head;

    rx_packet_ctrl_if #(.CNT_W(CNT_W)) bus ();

    rx_packet_ctrl #(.MAX_BYTES(MAXB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe must match the oldest queued byte on time.
    always @(negedge clk) begin
        if (bus.pid_valid === 1'b1) pv_cnt++;
        if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_write: data %h due cycle %0d not seen by cycle %0d",
                     sb_q[0].data, sb_q[0].due, cyc);
            void'(sb_q.pop_front());
        end
        if (bus.w_enable === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got data %h at cycle %0d, want no write",
                         bus.w_data, cyc);
            end else begin
                head = sb_q.pop_front();
                if (bus.w_data !== head.data || cyc != head.due) begin
                    errors++;
                    $display("FAIL write_data: got %h at cycle %0d, want %h at cycle %0d",
                             bus.w_data, cyc, head.data, head.due);
                end
            end
        end
    end

    // Drives one cycle of inputs just after the active edge.
    task automatic cycle_in(input logic de, input logic bv, input logic [7:0] b,
                            input logic e, input logic ff, input bit exp_wr);
        @(posedge clk);
        #1;
        bus.d_edge     = de;
        bus.byte_valid = bv;
        bus.rx_byte    = b;
        bus.eop        = e;
        bus.fifo_full  = ff;
        if (exp_wr) sb_q.push_back('{data: b, due: cyc + 1});
    endtask

    task automatic idle();
        cycle_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain_check(input string name);
        idle();
        idle();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected writes outstanding, want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus.d_edge = 1'b0; bus.byte_valid = 1'b0; bus.rx_byte = 8'h00;
        bus.eop = 1'b0; bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.w_enable, bus.w_data, bus.pid, bus.pid_valid, bus.rcving, bus.r_error,
             bus.byte_count} !== {1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_values: got we=%b wd=%h pid=%h pv=%b rcv=%b err=%b cnt=%0d, want all zero",
                     bus.w_enable, bus.w_data, bus.pid, bus.pid_valid, bus.rcving,
                     bus.r_error, bus.byte_count);
        end
        n_rst = 1'b1;
    endtask

    task automatic test_good_packet();
        logic [7:0] pay [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int pv0 = pv_cnt;
        cycle_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.rcving !== 1'b1) begin
            errors++;
            $display("FAIL good_rcving_start: got %b want 1", bus.rcving);
        end
        cycle_in(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
        foreach (pay[i]) cycle_in(1'b0, 1'b1, pay[i], 1'b0, 1'b0, 1'b1);
        cycle_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        checks++;
        if (bus.byte_count !== 3'd4 || bus.pid !== 4'hC || bus.r_error !== 1'b0 ||
            bus.rcving !== 1'b0) begin
            errors++;
            $display("FAIL good_status: got cnt=%0d pid=%h err=%b rcv=%b, want cnt=4 pid=c err=0 rcv=0",
                     bus.byte_count, bus.pid, bus.r_error, bus.rcving);
        end
        drain_check("good");
        checks++;
        if (pv_cnt - pv0 != 1) begin
            errors++;
            $display("FAIL good_pid_valid: got %0d pulses want 1", pv_cnt - pv0);
        end
    endtask

    task automatic test_bad_sync();
        cycle_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h2D, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.r_error !== 1'b1) begin
            errors++;
            $display("FAIL bad_sync_err_rise: got %b want 1", bus.r_error);
        end
        cycle_in(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (3) idle();
        @(negedge clk);
        checks++;
        if (bus.r_error !== 1'b1 || bus.rcving !== 1'b0) begin
            errors++;
            $display("FAIL bad_sync_after_eop: got err=%b rcv=%b want err=1 rcv=0",
                     bus.r_error, bus.rcving);
        end
        drain_check("bad_sync");
    endtask

    task automatic test_pid_fail();
        cycle_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.r_error !== 1'b0) begin
            errors++;
            $display("FAIL pid_fail_err_cleared: got %b want 0", bus.r_error);
        end
        cycle_in(1'b0, 1'b1, 8'hC4, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        checks++;
        if (bus.r_error !== 1'b1) begin
            errors++;
            $display("FAIL pid_fail_err: got %b want 1", bus.r_error);
        end
        // Handshake packet: PID only, no payload.
        cycle_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'hD2, 1'b0, 1'b0, 1'b1);
        cycle_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        checks++;
        if (bus.r_error !== 1'b0 || bus.pid !== 4'hD || bus.byte_count !== 3'd0 ||
            bus.rcving !== 1'b0) begin
            errors++;
            $display("FAIL handshake_status: got err=%b pid=%h cnt=%0d rcv=%b, want err=0 pid=d cnt=0 rcv=0",
                     bus.r_error, bus.pid, bus.byte_count, bus.rcving);
        end
        drain_check("pid_fail");
    endtask

    task automatic test_overrun();
        cycle_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < MAXB; i++) cycle_in(1'b0, 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b1);
        cycle_in(1'b0, 1'b1, 8'hF5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.byte_count !== 3'd4 || bus.r_error !== 1'b0) begin
            errors++;
            $display("FAIL overrun_at_max: got cnt=%0d err=%b want cnt=4 err=0",
                     bus.byte_count, bus.r_error);
        end
        cycle_in(1'b0, 1'b1, 8'hF6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.r_error !== 1'b1 || bus.byte_count !== 3'd4) begin
            errors++;
            $display("FAIL overrun_err: got err=%b cnt=%0d want err=1 cnt=4",
                     bus.r_error, bus.byte_count);
        end
        cycle_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        checks++;
        if (bus.byte_count !== 3'd4 || bus.r_error !== 1'b1 || bus.rcving !== 1'b0) begin
            errors++;
            $display("FAIL overrun_after_eop: got cnt=%0d err=%b rcv=%b want cnt=4 err=1 rcv=0",
                     bus.byte_count, bus.r_error, bus.rcving);
        end
        drain_check("overrun");
    endtask

    task automatic test_backpressure();
        cycle_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        cycle_in(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
        cycle_in(1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.r_error !== 1'b1 || bus.byte_count !== 3'd1) begin
            errors++;
            $display("FAIL backpressure_err: got err=%b cnt=%0d want err=1 cnt=1",
                     bus.r_error, bus.byte_count);
        end
        cycle_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drain_check("backpressure");
    endtask

    task automatic test_simultaneous();
        cycle_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h69, 1'b0, 1'b0, 1'b1);
        cycle_in(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        // Already back in IDLE: a stray byte must be ignored.
        cycle_in(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.rcving !== 1'b0 || bus.r_error !== 1'b0 || bus.byte_count !== 3'd1) begin
            errors++;
            $display("FAIL simultaneous_status: got rcv=%b err=%b cnt=%0d want rcv=0 err=0 cnt=1",
                     bus.rcving, bus.r_error, bus.byte_count);
        end
        drain_check("simultaneous");
    endtask

    task automatic test_reset_mid_packet();
        cycle_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
        cycle_in(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        cycle_in(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        #1;
        n_rst = 1'b0;
        bus.byte_valid = 1'b1;
        bus.rx_byte    = 8'h33;
        #1;
        checks++;
        if ({bus.w_enable, bus.w_data, bus.pid, bus.pid_valid, bus.rcving, bus.r_error,
             bus.byte_count} !== {1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_mid_values: got we=%b wd=%h pid=%h pv=%b rcv=%b err=%b cnt=%0d, want all zero",
                     bus.w_enable, bus.w_data, bus.pid, bus.pid_valid, bus.rcving,
                     bus.r_error, bus.byte_count);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        n_rst = 1'b1;
        // Without a fresh d_edge nothing is accepted.
        cycle_in(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h4B, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        checks++;
        if (bus.rcving !== 1'b0 || bus.pid !== 4'h0) begin
            errors++;
            $display("FAIL reset_needs_d_edge: got rcv=%b pid=%h want rcv=0 pid=0",
                     bus.rcving, bus.pid);
        end
        cycle_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b1, 8'h4B, 1'b0, 1'b0, 1'b1);
        cycle_in(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        cycle_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        checks++;
        if (bus.pid !== 4'h4 || bus.byte_count !== 3'd1 || bus.r_error !== 1'b0 ||
            bus.rcving !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_packet: got pid=%h cnt=%0d err=%b rcv=%b want pid=4 cnt=1 err=0 rcv=0",
                     bus.pid, bus.byte_count, bus.r_error, bus.rcving);
        end
        drain_check("reset_mid");
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        pv_cnt = 0;
        test_reset();
        test_good_packet();
        test_bad_sync();
        test_pid_fail();
        test_overrun();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
